// File: rtl/z80_exec_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// z80_exec_sequencer_if : loader / CPU-bus / register-set handshake bundle.
// Optional timeout_err member exists only with Z80_EXEC_TIMEOUT_EN.
// Revision 1.0
//------------------------------------------------------------------------------
interface z80_exec_sequencer_if;
   logic        load_active;
   logic        exec_req;
   logic [15:0] exec_addr_in;
   logic [1:0]  exec_method_in;
   logic        cpu_busak_n;
   logic        cpu_busrq_n;
   logic [15:0] execute_addr;
   logic [1:0]  execute_method;
   logic        execute_enable;
   logic        busy;
   logic        done;
`ifdef Z80_EXEC_TIMEOUT_EN
   logic        timeout_err;
`endif

   modport master (
      output load_active, exec_req, exec_addr_in, exec_method_in, cpu_busak_n,
      input  cpu_busrq_n, execute_addr, execute_method, execute_enable, busy, done
`ifdef Z80_EXEC_TIMEOUT_EN
      , input timeout_err
`endif
   );

   modport slave (
      input  load_active, exec_req, exec_addr_in, exec_method_in, cpu_busak_n,
      output cpu_busrq_n, execute_addr, execute_method, execute_enable, busy, done
`ifdef Z80_EXEC_TIMEOUT_EN
      , output timeout_err
`endif
   );
endinterface
`default_nettype wire

// File: rtl/z80_exec_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// z80_exec_sequencer : takes the Z80 bus and strobes the register-set loader.
// Optional BUSAK timeout via macro Z80_EXEC_TIMEOUT_EN.     Revision 1.0
//------------------------------------------------------------------------------
module z80_exec_sequencer #(
   parameter int SET_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 2
`ifdef Z80_EXEC_TIMEOUT_EN
   ,
   parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF
`endif
) (
   input  wire                   clk_sys,
   input  wire                   reset,
   z80_exec_sequencer_if.slave   bus
);

   localparam logic [3:0] SET_LOAD    = 4'(SET_CYCLES - 1);
   localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
`ifdef Z80_EXEC_TIMEOUT_EN
   localparam logic [15:0] ACK_LIMIT  = ACK_TIMEOUT - 16'd1;
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LOAD = 3'd1,
      REQ_BUS   = 3'd2,
      SET       = 3'd3,
      SETTLE    = 3'd4,
      RELEASE   = 3'd5
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
`ifdef Z80_EXEC_TIMEOUT_EN
   logic [15:0] ack_cnt;
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         cnt                <= 4'd0;
         bus.cpu_busrq_n    <= 1'b1;
         bus.execute_enable <= 1'b0;
         bus.execute_addr   <= 16'h0000;
         bus.execute_method <= 2'b00;
         bus.busy           <= 1'b0;
         bus.done           <= 1'b0;
`ifdef Z80_EXEC_TIMEOUT_EN
         ack_cnt            <= 16'd0;
         bus.timeout_err    <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.exec_req) begin
                  bus.execute_addr   <= bus.exec_addr_in;
                  bus.execute_method <= bus.exec_method_in;
                  bus.busy           <= 1'b1;
                  if (bus.load_active) begin
                     state <= WAIT_LOAD;
                  end else begin
                     state           <= REQ_BUS;
                     bus.cpu_busrq_n <= 1'b0;
`ifdef Z80_EXEC_TIMEOUT_EN
                     ack_cnt         <= 16'd0;
`endif
                  end
               end
            end
            WAIT_LOAD: begin
               if (!bus.load_active) begin
                  state           <= REQ_BUS;
                  bus.cpu_busrq_n <= 1'b0;
`ifdef Z80_EXEC_TIMEOUT_EN
                  ack_cnt         <= 16'd0;
`endif
               end
            end
            REQ_BUS: begin
               if (!bus.cpu_busak_n) begin
                  state              <= SET;
                  cnt                <= SET_LOAD;
                  bus.execute_enable <= 1'b1;
`ifdef Z80_EXEC_TIMEOUT_EN
               end else if (ack_cnt == ACK_LIMIT) begin
                  // Give the bus back without ever touching the register-set block.
                  state           <= IDLE;
                  bus.cpu_busrq_n <= 1'b1;
                  bus.timeout_err <= 1'b1;
                  bus.done        <= 1'b1;
                  bus.busy        <= 1'b0;
               end else begin
                  ack_cnt <= ack_cnt + 16'd1;
`endif
               end
            end
            SET: begin
               if (cnt == 4'd0) begin
                  bus.execute_enable <= 1'b0;
                  if (SETTLE_CYCLES == 0) begin
                     state           <= RELEASE;
                     bus.cpu_busrq_n <= 1'b1;
                  end else begin
                     state <= SETTLE;
                     cnt   <= SETTLE_LOAD;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            SETTLE: begin
               if (cnt == 4'd0) begin
                  state           <= RELEASE;
                  bus.cpu_busrq_n <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RELEASE: begin
               if (bus.cpu_busak_n) begin
                  state    <= IDLE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_z80_exec_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// tb_z80_exec_sequencer : directed stimulus against a timeline model of the
// sequencer, plus literal checks of strobe width, latency and counts.
//------------------------------------------------------------------------------
module tb_z80_exec_sequencer;
   localparam int SET_C    = 4;
   localparam int SETTLE_C = 2;
   localparam int ACK_TO   = 100;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   int   n_cmp   = 0;
   int   n_err   = 0;

   z80_exec_sequencer_if bus();

   z80_exec_sequencer #(
      .SET_CYCLES(SET_C),
      .SETTLE_CYCLES(SETTLE_C)
`ifdef Z80_EXEC_TIMEOUT_EN
      , .ACK_TIMEOUT(16'd100)
`endif
   ) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Timeline model: edge numbers of request start and bus grant define everything.
   int          e = 0;
   bit          m_active, m_loadwait, m_done, m_tmo;
   int          m_g, m_rq;
   logic [15:0] m_addr;
   logic [1:0]  m_meth;

   always @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         m_active = 0; m_loadwait = 0; m_done = 0; m_tmo = 0;
         m_g = -1; m_rq = -1; m_addr = '0; m_meth = '0;
      end else begin
         e++;
         m_done = 0;
         if (!m_active) begin
            if (bus.exec_req === 1'b1) begin
               m_active = 1; m_addr = bus.exec_addr_in; m_meth = bus.exec_method_in;
               m_loadwait = bus.load_active; m_g = -1; m_rq = e;
            end
         end else if (m_loadwait) begin
            if (!bus.load_active) begin m_loadwait = 0; m_rq = e; end
         end else if (m_g < 0) begin
            if (bus.cpu_busak_n === 1'b0) m_g = e;
`ifdef Z80_EXEC_TIMEOUT_EN
            else if (e - m_rq >= ACK_TO) begin m_active = 0; m_done = 1; m_tmo = 1; end
`endif
         end else if (e > m_g + SET_C + SETTLE_C && bus.cpu_busak_n === 1'b1) begin
            m_active = 0; m_done = 1;
         end
      end
   end

   always @(negedge clk_sys) begin
      if (!reset) begin
         check("busy", bus.busy, m_active);
         check("done", bus.done, m_done);
         check("execute_enable", bus.execute_enable,
               m_active && m_g >= 0 && e >= m_g && e < m_g + SET_C);
         check("cpu_busrq_n", bus.cpu_busrq_n,
               !(m_active && !m_loadwait && (m_g < 0 || e < m_g + SET_C + SETTLE_C)));
         check("execute_addr", bus.execute_addr, m_addr);
         check("execute_method", bus.execute_method, m_meth);
`ifdef Z80_EXEC_TIMEOUT_EN
         check("timeout_err", bus.timeout_err, m_tmo);
`endif
      end
   end

   // Bus arbiter: grants after ack_delay cycles of BUSRQ low, drops grant at once.
   int ack_delay = 1;
   bit ack_never = 0;
   int lo_cnt    = 0;
   always @(negedge clk_sys) begin
      if (bus.cpu_busrq_n === 1'b0) begin
         lo_cnt++;
         if (!ack_never && lo_cnt >= ack_delay + 1) bus.cpu_busak_n = 1'b0;
      end else begin
         lo_cnt = 0;
         bus.cpu_busak_n = 1'b1;
      end
   end

   int en_cycles, done_cnt, post_en_lo, first_en_edge, lo_in_load, req_edge;
   always @(negedge clk_sys) begin
      if (!reset) begin
         if (bus.execute_enable) begin
            en_cycles++;
            if (first_en_edge < 0) first_en_edge = e;
         end
         if (bus.done) done_cnt++;
         if (!bus.cpu_busrq_n && !bus.execute_enable && en_cycles > 0) post_en_lo++;
         if (bus.load_active && !bus.cpu_busrq_n) lo_in_load++;
      end
   end

   task automatic step();
      @(negedge clk_sys); #1;
   endtask

   task automatic clear_mon();
      en_cycles = 0; done_cnt = 0; post_en_lo = 0; first_en_edge = -1; lo_in_load = 0;
   endtask

   task automatic request(input logic [15:0] a, input logic [1:0] m);
      step();
      bus.exec_req = 1'b1; bus.exec_addr_in = a; bus.exec_method_in = m;
      step();
      req_edge = e;
      bus.exec_req = 1'b0;
   endtask

   task automatic wait_done(input int max, input string name);
      for (int i = 0; i < max; i++) begin
         if (done_cnt > 0) break;
         step();
      end
      check(name, done_cnt > 0, 1'b1);
   endtask

   task automatic wait_enable(input string name);
      for (int i = 0; i < 50; i++) begin
         if (bus.execute_enable) break;
         step();
      end
      check(name, bus.execute_enable, 1'b1);
   endtask

   initial begin
      bus.load_active = 0; bus.exec_req = 0; bus.exec_addr_in = '0; bus.exec_method_in = '0;
      repeat (3) step();
      reset = 0;
      step();
      check("rst_busrq_n", bus.cpu_busrq_n, 1'b1);
      check("rst_enable", bus.execute_enable, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_addr", bus.execute_addr, 16'h0000);

      // Basic run, grant one cycle after BUSRQ
      clear_mon(); ack_delay = 1;
      request(16'h5200, 2'b00);
      wait_done(100, "basic_done_seen");
      repeat (3) step();
      check("basic_en_cycles", en_cycles, 4);
      check("basic_addr", bus.execute_addr, 16'h5200);
      check("basic_busrq_after_en", post_en_lo, 2);
      check("basic_done_count", done_cnt, 1);
      check("basic_latency", first_en_edge - req_edge, 2);

      // Immediate grant: two edges from request to strobe
      clear_mon(); ack_delay = 0;
      request(16'hA5A5, 2'b11);
      wait_done(100, "fast_done_seen");
      check("fast_latency_edges", first_en_edge - req_edge + 1, 2);
      check("fast_method", bus.execute_method, 2'b11);

      // Load pending for 50 cycles
      clear_mon(); ack_delay = 1;
      step(); bus.load_active = 1'b1;
      request(16'h4000, 2'b01);
      repeat (48) step();
      check("load_busrq_low_cnt", lo_in_load, 0);
      check("load_busy", bus.busy, 1'b1);
      bus.load_active = 1'b0;
      step();
      check("load_busrq_after_fall", bus.cpu_busrq_n, 1'b0);
      wait_done(100, "load_done_seen");
      check("load_en_cycles", en_cycles, 4);

      // Second request during SET is ignored
      clear_mon();
      request(16'h5200, 2'b00);
      wait_enable("ign_enable_seen");
      bus.exec_req = 1'b1; bus.exec_addr_in = 16'h1234; bus.exec_method_in = 2'b10;
      step();
      bus.exec_req = 1'b0;
      wait_done(100, "ign_done_seen");
      repeat (5) step();
      check("ign_addr", bus.execute_addr, 16'h5200);
      check("ign_done_count", done_cnt, 1);

      // Reset during SET acts before any clock edge
      clear_mon();
      request(16'h7777, 2'b01);
      wait_enable("rst_mid_enable_seen");
      reset = 1'b1;
      #1;
      check("rst_mid_enable", bus.execute_enable, 1'b0);
      check("rst_mid_busrq_n", bus.cpu_busrq_n, 1'b1);
      check("rst_mid_busy", bus.busy, 1'b0);
      step(); step();
      reset = 1'b0;
      step();

      // Slow acknowledge
      clear_mon(); ack_delay = 300;
      request(16'h5200, 2'b00);
      wait_done(400, "slow_done_seen");
      check("slow_latency", first_en_edge - req_edge, 301);
      check("slow_en_cycles", en_cycles, 4);
      ack_delay = 1;

`ifdef Z80_EXEC_TIMEOUT_EN
      // BUSAK never answers
      clear_mon(); ack_never = 1;
      request(16'hBEEF, 2'b10);
      wait_done(ACK_TO + 50, "tmo_done_seen");
      step();
      check("tmo_err", bus.timeout_err, 1'b1);
      check("tmo_en_cycles", en_cycles, 0);
      check("tmo_busrq_n", bus.cpu_busrq_n, 1'b1);
      check("tmo_done_count", done_cnt, 1);
      ack_never = 0;
`endif

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
